// File: rtl/mips_boot_loader_if.sv
// Loader-side bundle: host stream in, instruction-memory writes and core control out.
// master = host/stream source driving start/len/data; slave = the boot loader.
// Pure wiring; all timing lives in mips_boot_loader.
interface mips_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start_i;
  logic [ADDR_W:0]   len_i;
  logic [31:0]       data_i;
  logic              valid_i;
  logic              ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              cpu_rst_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, len_i, data_i, valid_i,
    input  ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_o, done_o, err_o
  );

  modport slave (
    input  start_i, len_i, data_i, valid_i,
    output ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_o, done_o, err_o
  );
endinterface

// File: rtl/mips_boot_loader.sv
// Boot loader: streams len words into instruction memory, verifies a 32-bit additive checksum, releases the core.
// Latency: memory write registered one cycle after each accepted word; state outputs decoded from state.
// Backpressure: ready_o high only while loading/checking; valid_i low stalls with no state change.
module mips_boot_loader #(
  parameter int ADDR_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mips_boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Largest legal payload: the full memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [31:0]       r_sum;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_len_bad;
  logic [ADDR_W:0]   w_cnt_nxt;

  assign w_len_bad = (bus.len_i == '0) || (bus.len_i > CAP);
  assign w_cnt_nxt = r_cnt + 1'b1;

  // Loader FSM with registered memory-write port, counter and running checksum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (bus.start_i) begin
            r_len   <= bus.len_i;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= w_len_bad ? S_ERR : S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.valid_i) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= bus.data_i;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= r_sum + bus.data_i;
            if (w_cnt_nxt == r_len) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // The word after the payload is the checksum; it is never written to memory.
          if (bus.valid_i) begin
            r_state <= (bus.data_i == r_sum) ? S_RUN : S_ERR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and core control are pure state decodes so reset takes effect immediately.
  assign bus.ready_o      = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign bus.cpu_rst_o    = (r_state != S_RUN);
  assign bus.done_o       = (r_state == S_RUN);
  assign bus.err_o        = (r_state == S_ERR);
  assign bus.imem_we_o    = r_we;
  assign bus.imem_addr_o  = r_addr;
  assign bus.imem_wdata_o = r_wdata;

endmodule
